// File: rtl/key_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_load_ctrl
// Brief    : Serial key loader for a locked combinational netlist. Shifts a
//            key in LSB first with a trailing odd-parity bit, applies it
//            atomically on a valid commit, then holds key_valid low for a
//            settle window so cyclic netlists can resolve.
// Options  : KEY_LOAD_ONCE_EN - when defined, only the first valid commit
//            after reset is accepted (OTP-style key handling).
// Revision : 1.0 - initial release
// ============================================================================
module key_load_ctrl #(
  parameter int KEY_W      = 4,
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             key_sdi,
  input  logic             key_sen,
  input  logic             key_commit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  localparam logic [CNT_W-1:0] C_FULL_CNT   = CNT_W'(KEY_W + 1);
  localparam logic [CNT_W-1:0] C_OVF_CNT    = CNT_W'(KEY_W + 2);
  localparam logic [CNT_W-1:0] C_SETTLE_INI = CNT_W'(SETTLE_CYC - 1);

  logic [1:0]       state_q,      state_d;
  logic [KEY_W:0]   shreg_q,      shreg_d;
  logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [KEY_W-1:0] key_out_q,    key_out_d;
  logic             err_q,        err_d;
  logic             w_locked;
  logic             w_commit_ok;

`ifdef KEY_LOAD_ONCE_EN
  logic programmed_q, programmed_d;
  assign w_locked = programmed_q;
`else
  assign w_locked = 1'b0;
`endif

  // A commit is good only with exactly KEY_W+1 bits shifted and odd parity
  assign w_commit_ok = (bit_cnt_q == C_FULL_CNT) && (^shreg_q) && !w_locked;

  // Next-state logic: shifting, commit evaluation and settle countdown
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    settle_cnt_d = settle_cnt_q;
    key_out_d    = key_out_q;
    err_d        = err_q;
`ifdef KEY_LOAD_ONCE_EN
    programmed_d = programmed_q;
`endif
    case (state_q)
      ST_SETTLE: begin
        // Shifter and commit are frozen while the netlist settles
        if (settle_cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      ST_IDLE, ST_READY: begin
        if (key_commit) begin
          // Commit has priority; a same-cycle shift bit is dropped
          bit_cnt_d = '0;
          if (w_commit_ok) begin
            key_out_d    = shreg_q[KEY_W-1:0];
            err_d        = 1'b0;
            state_d      = ST_SETTLE;
            settle_cnt_d = C_SETTLE_INI;
`ifdef KEY_LOAD_ONCE_EN
            programmed_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end else if (key_sen) begin
          shreg_d = {key_sdi, shreg_q[KEY_W:1]};
          if (bit_cnt_q != C_OVF_CNT) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset aborting any operation
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      key_out_q    <= '0;
      err_q        <= 1'b0;
`ifdef KEY_LOAD_ONCE_EN
      programmed_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      key_out_q    <= key_out_d;
      err_q        <= err_d;
`ifdef KEY_LOAD_ONCE_EN
      programmed_q <= programmed_d;
`endif
    end
  end

  assign key_out   = key_out_q;
  assign err       = err_q;
  assign key_valid = (state_q == ST_READY);
  assign busy      = (state_q == ST_SETTLE);

endmodule
`default_nettype wire
